// File: rtl/line_rowmask.sv
// line_rowmask: collects Bresenham points for the next scanline into a
// one-row bitmask and replays it as pixel_on while the raster sweeps that row.
// Two ping-pong banks: one fills while the other displays; they swap at the
// last column of every row, and the bank leaving display is cleared then.
// Optional feature macro: LINE_ROWMASK_THICK_EN (also set bit pt_x+1).
module line_rowmask #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 525,
  parameter int DROP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x_cnt,
  input  logic [9:0]        y_cnt,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic [10:0]       pt_x,
  input  logic [9:0]        pt_y,
  output logic              pixel_on,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic [1:0][H_ACTIVE-1:0] bank_q, bank_d;
  logic                     sel_q, sel_d;      // index of the display bank
  logic                     pixel_on_q, pixel_on_d;
  logic [DROP_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic [9:0] fill_row;
  logic       swap, pt_drop_row, pt_match, accept, wr_en, drop, fill_sel, disp_bit;

  // Handshake: decide from pt_y against the row currently being filled.
  always_comb begin
    fill_row    = (y_cnt == V_LAST) ? 10'd0 : y_cnt + 10'd1;
    swap        = (x_cnt == H_LAST);
    pt_drop_row = (pt_y >= V_ACT) || (pt_y < fill_row);
    pt_match    = (pt_y == fill_row);
    // Swap cycle always blocks so a write never collides with the bank clear.
    pt_ready    = !reset && !swap && (pt_drop_row || pt_match);
    accept      = pt_valid && pt_ready;
    wr_en       = accept && !pt_drop_row && (pt_x < H_ACT);
    drop        = accept && !wr_en;
    fill_sel    = ~sel_q;
  end

  // Bank update: swap/clear at end of row, otherwise set bits of accepted points.
  always_comb begin
    bank_d = bank_q;
    sel_d  = sel_q;
    if (swap) begin
      bank_d[sel_q] = '0;
      sel_d         = ~sel_q;
    end else if (wr_en) begin
      for (int i = 0; i < H_ACTIVE; i++) begin
`ifdef LINE_ROWMASK_THICK_EN
        if ((pt_x == 11'(i)) || ((pt_x + 11'd1) == 11'(i))) bank_d[fill_sel][i] = 1'b1;
`else
        if (pt_x == 11'(i)) bank_d[fill_sel][i] = 1'b1;
`endif
      end
    end
  end

  // Display lookup and saturating drop counter.
  always_comb begin
    disp_bit = 1'b0;
    for (int i = 0; i < H_ACTIVE; i++) begin
      if (x_cnt == 11'(i)) disp_bit = bank_q[sel_q][i];
    end
    pixel_on_d = (x_cnt < H_ACT) && (y_cnt < V_ACT) && disp_bit;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q     <= '0;
      sel_q      <= 1'b0;
      pixel_on_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      bank_q     <= bank_d;
      sel_q      <= sel_d;
      pixel_on_q <= pixel_on_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pixel_on = pixel_on_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_line_rowmask.sv
// tb_line_rowmask: directed + random stimulus against a per-target-row model.
module tb_line_rowmask;
  localparam int HA = 16, VA = 12, HT = 20, VT = 14, DW = 4;
  localparam int TMO = 3 * HT * VT;

  logic          clk = 1'b0, reset = 1'b1;
  logic [10:0]   x_cnt = '0, pt_x = '0;
  logic [9:0]    y_cnt = '0, pt_y = '0;
  logic          pt_valid = 1'b0, pt_ready, pixel_on;
  logic [DW-1:0] drop_cnt;

  line_rowmask #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pixel_on(pixel_on), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (y=%0d x=%0d)", nm, act, exp, y_cnt, x_cnt);
    end
  endtask

  // Model: map[r] holds the points collected for target row r. Row r is shown
  // while the raster is on row r; map[r] is emptied when row r becomes the
  // fill target (at the swap that starts row r-1).
  logic [HA-1:0] map [VT];
  logic [HA-1:0] hitmask [VT];
  int  mdrop = 0, prev_x = 0, prev_y = 0;
  bit  exp_pix = 0, rec_en = 0;

  function automatic int nxt_row(input int r);
    return (r == VT-1) ? 0 : r + 1;
  endfunction

  // Compare process: check outputs every cycle, then advance the model.
  always @(negedge clk) begin
    int fill, xi, yi, px, py;
    bit swap, rdy;
    xi = int'(x_cnt); yi = int'(y_cnt); px = int'(pt_x); py = int'(pt_y);
    if (reset) begin
      chk("rst_ready", pt_ready, 0);
      chk("rst_pixel", pixel_on, 0);
      chk("rst_drop", drop_cnt, 0);
      for (int r = 0; r < VT; r++) map[r] = '0;
      mdrop = 0; exp_pix = 0;
    end else begin
      fill = nxt_row(yi);
      swap = (xi == HT-1);
      rdy  = !swap && (py >= VA || py <= fill);
      chk("pt_ready", pt_ready, rdy);
      chk("pixel_on", pixel_on, exp_pix);
      chk("drop_cnt", drop_cnt, mdrop);
      if (rec_en && pixel_on && prev_x < HA && prev_y < VA) hitmask[prev_y][prev_x] = 1'b1;
      exp_pix = (xi < HA) && (yi < VA) && map[yi][xi];
      if (pt_valid && rdy) begin
        if (py < VA && py == fill && px < HA) begin
          map[fill][px] = 1'b1;
`ifdef LINE_ROWMASK_THICK_EN
          if (px + 1 < HA) map[fill][px+1] = 1'b1;
`endif
        end else if (mdrop != (1 << DW) - 1) mdrop++;
      end
      if (swap) map[nxt_row(nxt_row(yi))] = '0;
    end
    prev_x = xi; prev_y = yi;
  end

  task automatic tick();
    @(posedge clk); #1;
    if (int'(x_cnt) == HT-1) begin
      x_cnt = '0;
      y_cnt = (int'(y_cnt) == VT-1) ? 10'd0 : y_cnt + 10'd1;
    end else x_cnt = x_cnt + 11'd1;
  endtask

  task automatic advance_to(input int y, input int x);
    int n = 0;
    while (!(int'(y_cnt) == y && int'(x_cnt) == x) && n < TMO) begin tick(); n++; end
    if (n >= TMO) chk("advance_timeout", n, -1);
  endtask

  task automatic send(input int px, input int py, output int w);
    bit done = 0;
    pt_x = 11'(px); pt_y = 10'(py); pt_valid = 1'b1; w = 0;
    while (!done) begin
      @(negedge clk);
      if (pt_ready) done = 1; else w++;
      tick();
      if (w > TMO) begin chk("send_timeout", w, -1); done = 1; end
    end
    pt_valid = 1'b0;
  endtask

  function automatic logic [HA-1:0] diag_mask(input int c);
    logic [HA-1:0] m = '0;
    m[c] = 1'b1;
`ifdef LINE_ROWMASK_THICK_EN
    if (c + 1 < HA) m[c+1] = 1'b1;
`endif
    return m;
  endfunction

  initial begin
    int w;
    logic [HA-1:0] e;
    repeat (3) tick();
    reset = 1'b0;

    // Stale, off-row-end and below-screen points: all taken at once, all dropped.
    advance_to(8, 3);
    send(5, 3, w);  chk("stale_wait", w, 0);
    send(20, 9, w); chk("xrange_wait", w, 0);
    send(5, 13, w); chk("yrange_wait", w, 0);
    @(negedge clk); chk("drop3", drop_cnt, 3);

    // Single point held from row 0: stalls two full rows.
    advance_to(0, 0);
    send(10, 3, w); chk("single_wait", w, 2 * HT);

    // Swap collision: blocked on the swap cycle, stale (dropped) the next.
    advance_to(4, HT-1);
    pt_x = 11'd5; pt_y = 10'd5; pt_valid = 1'b1;
    @(negedge clk); chk("swap_block", pt_ready, 0);
    tick();
    @(negedge clk); chk("swap_after", pt_ready, 1);
    tick(); pt_valid = 1'b0;

    // Full diagonal from the last blanking row, plus the bottom-right pixel.
    advance_to(VT-3, 0);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int r = 0; r < VT; r++) hitmask[r] = '0;
    rec_en = 1;
    advance_to(VT-1, 2);
    for (int r = 0; r < VA; r++) send(r, r, w);
    send(HA-1, VA-1, w);
    advance_to(VA, 1);
    rec_en = 0;
    for (int r = 0; r < VA; r++) begin
      e = diag_mask(r);
      if (r == VA-1) e[HA-1] = 1'b1;
      chk($sformatf("diag_row%0d", r), int'(hitmask[r]), int'(e));
    end
    @(negedge clk); chk("diag_drop", drop_cnt, 0);

    // Reset mid-frame discards the pending point; a new one works afterwards.
    advance_to(5, 2);
    send(7, 6, w);
    advance_to(5, 10);
    reset = 1'b1;
    @(negedge clk); chk("midrst_pixel", pixel_on, 0); chk("midrst_drop", drop_cnt, 0);
    tick(); tick(); reset = 1'b0;
    for (int r = 0; r < VT; r++) hitmask[r] = '0;
    rec_en = 1;
    send(3, 6, w); chk("midrst_wait", w, 0);
    advance_to(7, 0);
    rec_en = 0;
    chk("midrst_row6", int'(hitmask[6]), int'(diag_mask(3)));

    // Random points clustered around the fill row; drop_cnt saturates.
    for (int i = 0; i < 4000; i++) begin
      int f;
      f = nxt_row(int'(y_cnt));
      pt_valid = 1'($urandom_range(0, 1));
      pt_x = 11'($urandom_range(0, HT-1));
      case ($urandom_range(0, 3))
        0: pt_y = 10'(f);
        1: pt_y = 10'(f + 1);
        2: pt_y = 10'($urandom_range(0, VT+1));
        default: pt_y = 10'((f == 0) ? 0 : f - 1);
      endcase
      tick();
    end
    pt_valid = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
